// File: rtl/wb8_pkg.sv
// Shared definitions for the 8-bit Wishbone bus decoder: FSM encoding, error data, SoC address map.
// Optional bus-error watchdog is enabled by defining WB8_BUS_DECODER_TIMEOUT_EN.
package wb8_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam logic [7:0]  WB8_ERR_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ERR
    } wb8_state_e;

    // Standard SoC map; anything unmatched falls through to RAM (the default slave).
    localparam logic [WB_ADR_W-1:0] ROM_BASE    = 32'hFFFF_F000;
    localparam logic [WB_ADR_W-1:0] ROM_MASK    = 32'hFFFF_F800;
    localparam logic [WB_ADR_W-1:0] UART_BASE   = 32'hFFFF_F800;
    localparam logic [WB_ADR_W-1:0] UART_MASK   = 32'hFFFF_FF00;
    localparam logic [WB_ADR_W-1:0] SPI_BASE    = 32'hFFFF_F900;
    localparam logic [WB_ADR_W-1:0] SPI_MASK    = 32'hFFFF_FF00;
    localparam logic [WB_ADR_W-1:0] TIMER_BASE  = 32'hFFFF_FD00;
    localparam logic [WB_ADR_W-1:0] TIMER_MASK  = 32'hFFFF_FF00;
    localparam logic [WB_ADR_W-1:0] BUTTON_BASE = 32'hFFFF_FFE0;
    localparam logic [WB_ADR_W-1:0] BUTTON_MASK = 32'hFFFF_FFF0;
    localparam logic [WB_ADR_W-1:0] LEDS_BASE   = 32'hFFFF_FFF0;
    localparam logic [WB_ADR_W-1:0] LEDS_MASK   = 32'hFFFF_FFF0;

endpackage

// File: rtl/wb8_watchdog.sv
// Saturating BUSY-cycle counter with terminal-count flag for the bus decoder.
// Counter exists only when WB8_BUS_DECODER_TIMEOUT_EN is defined; otherwise tc is tied low.
module wb8_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

`ifdef WB8_BUS_DECODER_TIMEOUT_EN
    localparam int unsigned   CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = en && (cnt == TC_VAL);
`else
    logic        unused_inputs;
    logic [15:0] unused_timeout;

    assign unused_inputs  = ^{clk, rst_n, clr, en};
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign tc             = 1'b0;
`endif

endmodule

// File: rtl/wb8_bus_decoder.sv
// 8-bit Wishbone address decoder / response mux with per-access slave latch and abort handling.
// Define WB8_BUS_DECODER_TIMEOUT_EN to add the bus-error watchdog, ERR state and sticky error capture.
module wb8_bus_decoder
    import wb8_pkg::*;
#(
    parameter int unsigned           NSLAVES        = 6,
    parameter logic [32*NSLAVES-1:0] SLV_BASE       = {NSLAVES{32'h0}},
    parameter logic [32*NSLAVES-1:0] SLV_MASK       = {NSLAVES{32'h0}},
    parameter int unsigned           DEFAULT_SLAVE  = NSLAVES - 1,
    parameter int unsigned           TIMEOUT_CYCLES = 255
) (
    input  logic                  I_wb_clk,
    input  logic                  I_reset_n,
    input  logic [WB_ADR_W-1:0]   I_cpu_adr,
    input  logic                  I_cpu_stb,
    output logic [7:0]            O_cpu_dat,
    output logic                  O_cpu_ack,
    output logic                  O_cpu_stall,
    output logic [NSLAVES-1:0]    O_slv_stb,
    input  logic [8*NSLAVES-1:0]  I_slv_dat,
    input  logic [NSLAVES-1:0]    I_slv_ack,
    input  logic [NSLAVES-1:0]    I_slv_stall,
    input  logic                  I_err_clr,
    output logic                  O_bus_err,
    output logic [WB_ADR_W-1:0]   O_err_adr
);

    localparam int unsigned IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    wb8_state_e        state;
    logic [IDX_W-1:0]  sel_q;
    logic [IDX_W-1:0]  hit_idx;
    logic              hit_found;
    logic [IDX_W-1:0]  cur_idx;
    logic [7:0]        sel_dat;
    logic              sel_ack;
    logic              sel_stall;
    logic              access;
    logic              wd_clr;
    logic              wd_en;
    logic              wd_tc;

    // Lowest matching window wins; no match falls back to the default slave.
    always_comb begin
        hit_idx   = IDX_W'(DEFAULT_SLAVE);
        hit_found = 1'b0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (!hit_found &&
                ((I_cpu_adr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))) begin
                hit_idx   = IDX_W'(i);
                hit_found = 1'b1;
            end
        end
    end

    // In IDLE the live decode drives the slave side; once BUSY the latched index holds.
    assign cur_idx   = (state == ST_IDLE) ? hit_idx : sel_q;
    assign sel_dat   = I_slv_dat[{cur_idx, 3'b000} +: 8];
    assign sel_ack   = I_slv_ack[cur_idx];
    assign sel_stall = I_slv_stall[cur_idx];
    assign access    = I_reset_n && I_cpu_stb && (state != ST_ERR);

    always_comb begin
        O_slv_stb   = '0;
        O_cpu_dat   = '0;
        O_cpu_ack   = 1'b0;
        O_cpu_stall = 1'b0;
        if (access) begin
            O_slv_stb[cur_idx] = 1'b1;
            O_cpu_dat          = sel_dat;
            O_cpu_ack          = sel_ack;
            O_cpu_stall        = sel_stall;
        end else if (I_reset_n && (state == ST_ERR)) begin
            O_cpu_dat = WB8_ERR_DATA;
            O_cpu_ack = 1'b1;
        end
    end

    assign wd_clr = (state == ST_IDLE);
    assign wd_en  = (state == ST_BUSY);

    wb8_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk  (I_wb_clk),
        .rst_n(I_reset_n),
        .clr  (wd_clr),
        .en   (wd_en),
        .tc   (wd_tc)
    );

    always_ff @(posedge I_wb_clk) begin
        if (!I_reset_n) begin
            state <= ST_IDLE;
            sel_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_cpu_stb) begin
                        sel_q <= hit_idx;
                        if (!sel_ack) begin
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!I_cpu_stb || sel_ack) begin
                        state <= ST_IDLE;
                    end else if (wd_tc) begin
                        state <= ST_ERR;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef WB8_BUS_DECODER_TIMEOUT_EN
    logic [WB_ADR_W-1:0] adr_q;

    // Address is latched at the start of the access since the master may change it later.
    always_ff @(posedge I_wb_clk) begin
        if (!I_reset_n) begin
            adr_q     <= '0;
            O_bus_err <= 1'b0;
            O_err_adr <= '0;
        end else begin
            if ((state == ST_IDLE) && I_cpu_stb) begin
                adr_q <= I_cpu_adr;
            end
            if (state == ST_ERR) begin
                O_bus_err <= 1'b1;
                if (!O_bus_err) begin
                    O_err_adr <= adr_q;
                end
            end else if (I_err_clr) begin
                O_bus_err <= 1'b0;
                O_err_adr <= '0;
            end
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = I_err_clr;
    assign O_bus_err      = 1'b0;
    assign O_err_adr      = '0;
`endif

endmodule

// File: tb/tb_wb8_bus_decoder.sv
// Directed self-checking bench for wb8_bus_decoder (standard SoC map plus an overlapping-window instance).
// Timeout checks run when WB8_BUS_DECODER_TIMEOUT_EN is defined; otherwise the unbounded-wait checks run.
module tb_wb8_bus_decoder;
    import wb8_pkg::*;

    localparam int unsigned NS = 6;
    localparam logic [32*NS-1:0] STD_BASE = {32'hFFFF_FFFF, LEDS_BASE, TIMER_BASE, SPI_BASE, UART_BASE, ROM_BASE};
    localparam logic [32*NS-1:0] STD_MASK = {32'hFFFF_FFFF, LEDS_MASK, TIMER_MASK, SPI_MASK, UART_MASK, ROM_MASK};
    localparam logic [32*NS-1:0] OVL_BASE = {32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_F000, 32'hFFFF_F000};
    localparam logic [32*NS-1:0] OVL_MASK = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                             32'hFFFF_FF00, 32'hFFFF_F000};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   adr;
    logic          stb;
    logic [8*NS-1:0] slv_dat;
    logic [NS-1:0] slv_ack;
    logic [NS-1:0] slv_stall;
    logic          err_clr;

    logic [7:0]    m_dat, o_dat;
    logic          m_ack, o_ack, m_stall, o_stall, m_err, o_err;
    logic [NS-1:0] m_stb, o_stb;
    logic [31:0]   m_err_adr, o_err_adr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb8_bus_decoder #(
        .NSLAVES(NS), .SLV_BASE(STD_BASE), .SLV_MASK(STD_MASK),
        .DEFAULT_SLAVE(NS - 1), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .I_wb_clk(clk), .I_reset_n(rst_n), .I_cpu_adr(adr), .I_cpu_stb(stb),
        .O_cpu_dat(m_dat), .O_cpu_ack(m_ack), .O_cpu_stall(m_stall), .O_slv_stb(m_stb),
        .I_slv_dat(slv_dat), .I_slv_ack(slv_ack), .I_slv_stall(slv_stall),
        .I_err_clr(err_clr), .O_bus_err(m_err), .O_err_adr(m_err_adr)
    );

    wb8_bus_decoder #(
        .NSLAVES(NS), .SLV_BASE(OVL_BASE), .SLV_MASK(OVL_MASK),
        .DEFAULT_SLAVE(NS - 1), .TIMEOUT_CYCLES(8)
    ) u_ovl (
        .I_wb_clk(clk), .I_reset_n(rst_n), .I_cpu_adr(adr), .I_cpu_stb(stb),
        .O_cpu_dat(o_dat), .O_cpu_ack(o_ack), .O_cpu_stall(o_stall), .O_slv_stb(o_stb),
        .I_slv_dat(slv_dat), .I_slv_ack(slv_ack), .I_slv_stall(slv_stall),
        .I_err_clr(err_clr), .O_bus_err(o_err), .O_err_adr(o_err_adr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vec_adr [10];
    logic [5:0]  vec_stb [10];

    initial begin
        vec_adr[0] = 32'hFFFF_F000; vec_stb[0] = 6'b000001;
        vec_adr[1] = 32'hFFFF_F7FF; vec_stb[1] = 6'b000001;
        vec_adr[2] = 32'hFFFF_F800; vec_stb[2] = 6'b000010;
        vec_adr[3] = 32'hFFFF_F8FF; vec_stb[3] = 6'b000010;
        vec_adr[4] = 32'hFFFF_F9AB; vec_stb[4] = 6'b000100;
        vec_adr[5] = 32'hFFFF_FD10; vec_stb[5] = 6'b001000;
        vec_adr[6] = 32'hFFFF_FFF7; vec_stb[6] = 6'b010000;
        vec_adr[7] = 32'hFFFF_FFE4; vec_stb[7] = 6'b100000;
        vec_adr[8] = 32'h0000_1234; vec_stb[8] = 6'b100000;
        vec_adr[9] = 32'hFFFF_FA00; vec_stb[9] = 6'b100000;

        rst_n     = 1'b0;
        adr       = 32'hFFFF_F804;
        stb       = 1'b1;
        slv_dat   = {8'h66, 8'h55, 8'h44, 8'h33, 8'h5A, 8'h11};
        slv_ack   = '0;
        slv_stall = '0;
        err_clr   = 1'b0;

        // Reset: everything reads 0 even with a strobe present
        tick();
        tick();
        chk("rst_stb", 32'(m_stb), 32'h0);
        chk("rst_ack", 32'(m_ack), 32'h0);
        chk("rst_dat", 32'(m_dat), 32'h0);
        chk("rst_bus_err", 32'(m_err), 32'h0);
        chk("rst_err_adr", m_err_adr, 32'h0);
        stb   = 1'b0;
        rst_n = 1'b1;
        tick();

        // Overlapping windows: lowest index wins
        adr = 32'hFFFF_F010; stb = 1'b1;
        #1;
        chk("ovl_stb", 32'(o_stb), 32'h01);
        chk("std_rom_stb", 32'(m_stb), 32'h01);
        slv_ack = 6'b000001;
        #1;
        chk("idle_ack_pass", 32'(m_ack), 32'h1);
        chk("idle_ack_dat", 32'(m_dat), 32'h11);
        tick();

        // UART read, ack on 3rd cycle, address change ignored while BUSY
        slv_ack = '0; adr = 32'hFFFF_F804; stb = 1'b1;
        #1;
        chk("uart_stb_c1", 32'(m_stb), 32'h02);
        chk("uart_ack_c1", 32'(m_ack), 32'h0);
        tick();
        adr = 32'h0; slv_ack = 6'b100001; slv_stall = 6'b000010;
        #1;
        chk("uart_stb_c2", 32'(m_stb), 32'h02);
        chk("uart_foreign_ack", 32'(m_ack), 32'h0);
        chk("uart_stall", 32'(m_stall), 32'h1);
        tick();
        slv_ack = 6'b000010; slv_stall = '0;
        #1;
        chk("uart_ack_c3", 32'(m_ack), 32'h1);
        chk("uart_dat_c3", 32'(m_dat), 32'h5A);
        tick();
        stb = 1'b0; slv_ack = '0;
        #1;
        chk("idle_ack", 32'(m_ack), 32'h0);
        chk("idle_dat", 32'(m_dat), 32'h00);
        chk("idle_stb", 32'(m_stb), 32'h0);

        // Decode table, acked in the same cycle so the FSM stays in IDLE
        for (int i = 0; i < 10; i++) begin
            adr = vec_adr[i]; stb = 1'b1; slv_ack = '1;
            #1;
            chk($sformatf("decode_stb_%0d", i), 32'(m_stb), 32'(vec_stb[i]));
            chk($sformatf("decode_ack_%0d", i), 32'(m_ack), 32'h1);
            tick();
        end
        stb = 1'b0; slv_ack = '0;
        tick();

        // Default slave; foreign ack ignored; abort after 3 BUSY cycles
        adr = 32'h0000_1234; stb = 1'b1; slv_ack = 6'b001000;
        #1;
        chk("dflt_stb", 32'(m_stb), 32'h20);
        chk("dflt_ack_idle", 32'(m_ack), 32'h0);
        tick();
        chk("dflt_ack_busy", 32'(m_ack), 32'h0);
        tick();
        tick();
        chk("dflt_stb_busy3", 32'(m_stb), 32'h20);
        stb = 1'b0;
        #1;
        chk("abort_ack", 32'(m_ack), 32'h0);
        chk("abort_stb", 32'(m_stb), 32'h0);
        tick();
        chk("abort_no_err", 32'(m_err), 32'h0);
        adr = 32'hFFFF_F900; stb = 1'b1; slv_ack = 6'b000100;
        #1;
        chk("after_abort_stb", 32'(m_stb), 32'h04);
        chk("after_abort_ack", 32'(m_ack), 32'h1);
        chk("after_abort_dat", 32'(m_dat), 32'h33);
        tick();
        slv_ack = '0;

        // Reset asserted mid-BUSY
        adr = 32'hFFFF_F804; stb = 1'b1;
        tick();
        tick();
        rst_n = 1'b0; slv_ack = 6'b000010;
        #1;
        chk("inrst_stb", 32'(m_stb), 32'h0);
        chk("inrst_ack", 32'(m_ack), 32'h0);
        tick();
        chk("midrst_stb", 32'(m_stb), 32'h0);
        chk("midrst_ack", 32'(m_ack), 32'h0);
        chk("midrst_dat", 32'(m_dat), 32'h0);
        chk("midrst_stall", 32'(m_stall), 32'h0);
        rst_n = 1'b1; stb = 1'b0; slv_ack = '0;
        tick();

`ifdef WB8_BUS_DECODER_TIMEOUT_EN
        // Timeout after 8 BUSY cycles without ack
        adr = 32'hFFFF_F900; stb = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("to_wait_ack_%0d", k), 32'(m_ack), 32'h0);
            tick();
        end
        chk("to_err_ack", 32'(m_ack), 32'h1);
        chk("to_err_dat", 32'(m_dat), 32'hFF);
        chk("to_err_stb", 32'(m_stb), 32'h0);
        chk("to_err_flag_pre", 32'(m_err), 32'h0);
        stb = 1'b0;
        tick();
        chk("to_bus_err", 32'(m_err), 32'h1);
        chk("to_err_adr", m_err_adr, 32'hFFFF_F900);

        // Second timeout keeps the first address; clear coinciding with set loses
        adr = 32'hFFFF_FD00; stb = 1'b1;
        tick();
        repeat (8) tick();
        err_clr = 1'b1;
        #1;
        chk("to2_err_ack", 32'(m_ack), 32'h1);
        tick();
        err_clr = 1'b0; stb = 1'b0;
        chk("to2_bus_err", 32'(m_err), 32'h1);
        chk("to2_err_adr", m_err_adr, 32'hFFFF_F900);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_bus_err", 32'(m_err), 32'h0);
        chk("clr_err_adr", m_err_adr, 32'h0);
`else
        // Without the watchdog an unacked access waits indefinitely
        adr = 32'hFFFF_F900; stb = 1'b1;
        tick();
        repeat (1000) tick();
        chk("hang_ack", 32'(m_ack), 32'h0);
        chk("hang_stb", 32'(m_stb), 32'h04);
        chk("hang_bus_err", 32'(m_err), 32'h0);
        chk("hang_err_adr", m_err_adr, 32'h0);
        slv_ack = 6'b000100;
        #1;
        chk("hang_late_ack", 32'(m_ack), 32'h1);
        chk("hang_late_dat", 32'(m_dat), 32'h33);
        tick();
        stb = 1'b0; slv_ack = '0;
        tick();
        chk("hang_end_err", 32'(m_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
